icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage's instruction port and the instruction memory bus.
- Fetch presents `iaddr` and must see `idata` combinationally in the same cycle. On a hit that holds with no penalty.
- On a miss the cache asserts `stall`, refills the whole line from memory word by word using a req/ack handshake, then serves the instruction.
- `stall` is ORed into the pipeline's fetch-hold condition, so `pc` does not advance while it is high.

Parameters:
LINES, 16, number of cache lines; power of two, >= 2
WORDS, 4, 32-bit words per line; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
iaddr  in  32  fetch byte address from the fetch stage; bits [1:0] ignored
idata  out  32  instruction word for iaddr; meaningful only when stall=0
stall  out  1  1 = idata not valid this cycle, fetch must hold
flush  in  1  1-cycle pulse: invalidate entire cache (fence.i / self-modifying code)
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned memory read address; stable while mem_req=1 and no ack
mem_ack  in  1  memory accepts the request and returns mem_rdata this cycle
mem_rdata  in  32  read data, valid when mem_ack=1

Behaviour:
- Address split:
  - offset = iaddr[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - data array LINES x WORDS x 32 (no reset)
  - tag array LINES x tag width (no reset)
  - valid bits LINES x 1 (reset to 0)
- Lookup is combinational: hit = state==IDLE & valid[index] & tag match.
  - idata = data[index][offset] when hit, else 0.
  - stall = !hit.
- Reset (rst=0, asynchronous):
  - all valid bits 0, state IDLE, word counter 0, abort flag 0
  - mem_req=0, mem_addr=0, idata=0, stall=1
  - Reset mid-refill abandons the fill immediately; no line is marked valid.
- FSM states: IDLE, FILL.
- IDLE:
  - Miss (and rst=1, flush=0): latch line base = {iaddr[31:log2(WORDS)+2], zeros} and index, clear counter, go to FILL next cycle.
  - mem_req=0 in IDLE.
  - Detect cycle is cycle 0 of the miss.
- FILL:
  - mem_req=1; mem_addr = line base + 4*counter.
  - On mem_ack: write mem_rdata to data[latched index][counter], increment counter.
  - mem_req stays 1 across consecutive words. mem_addr updates the cycle after each ack.
  - On ack of word WORDS-1: write latched tag, set valid[latched index] unless abort flag set, clear abort, return to IDLE.
  - stall=1 throughout FILL.
- Miss penalty with zero-wait memory (ack every FILL cycle): stall high for WORDS+1 cycles; first hit on cycle WORDS+1.
- iaddr change during FILL (branch redirect):
  - The fill completes for the latched line regardless.
  - After returning to IDLE, the current iaddr is looked up again, which may miss again and start a new fill.
- flush:
  - In IDLE: all valid bits cleared at the edge. stall this cycle follows the pre-flush lookup. No fill starts in a flush cycle even on a miss.
  - In FILL: all valid bits cleared and abort flag set. The fill runs to completion, but the line is not marked valid.
  - Flush coincident with the final ack: flush wins, the line stays invalid.
- Counter width log2(WORDS); wraps to 0 after the last word.
- Memory must not see mem_req drop before ack while in FILL.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Cold miss then hit, default params, mem_ack tied 1:
  - Drive iaddr=0x0000_0104 after reset release.
  - Required: stall=1 for 5 cycles; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Then stall=0, idata = word returned for 0x104.
  - iaddr=0x10C next cycle hits with no stall.
- Conflict eviction:
  - Fill 0x0000_0100, then fetch 0x0000_0200 (same index 0, different tag).
  - Required: refill of 0x200-0x20C; a later 0x100 misses again.
- Wait states:
  - mem_ack asserted only every 3rd cycle.
  - Required: mem_addr held stable between acks, mem_req never drops, the 4 words land at the correct offsets, stall released one cycle after the final ack.
- Redirect mid-fill:
  - During a fill of 0x100, change iaddr to 0x340 after the second ack.
  - Required: fill of 0x100 completes and is marked valid, then a new fill of 0x340 begins; returning to 0x100 later hits.
- Flush:
  - With line 0x100 valid, pulse flush in IDLE; next fetch of 0x100 misses.
  - Pulse flush during a fill.
  - Required: the fill finishes but a subsequent fetch of the same address misses again.
- Async reset mid-fill:
  - Drop rst between acks.
  - Required: mem_req=0 and stall=1 immediately (no clock edge needed).
  - After release, all lines miss.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. The lookup is combinational.
// On a miss the whole line is refilled over a req/ack memory port.
module icache_dm #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OffW  = $clog2(WORDS);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned BaseW = 32 - 2 - OffW;
  localparam int unsigned TagW  = BaseW - IdxW;

  localparam logic [OffW-1:0] CntOne  = OffW'(1);
  localparam logic [OffW-1:0] CntLast = OffW'(WORDS - 1);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [BaseW-1:0]  base_q, base_d;
  logic [OffW-1:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [31:0]       data_q [LINES][WORDS];
  logic [TagW-1:0]   tag_q  [LINES];

  logic [OffW-1:0]   offset;
  logic [IdxW-1:0]   index;
  logic [TagW-1:0]   tag;
  logic [IdxW-1:0]   fill_idx;
  logic              hit;
  logic              data_we;
  logic              tag_we;
  logic              unused_addr_bits;

  assign offset           = iaddr[OffW+1:2];
  assign index            = iaddr[OffW+IdxW+1:OffW+2];
  assign tag              = iaddr[31:OffW+IdxW+2];
  assign fill_idx         = base_q[IdxW-1:0];
  assign unused_addr_bits = ^iaddr[1:0];

  // Hits are only served in idle so a fill in flight never exposes a partial line.
  assign hit   = (state_q == StIdle) && valid_q[index] && (tag_q[index] == tag);
  assign idata = hit ? data_q[index][offset] : '0;
  assign stall = !hit;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    valid_d  = valid_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    data_we  = 1'b0;
    tag_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          valid_d = '0;
        end else if (!hit) begin
          base_d  = iaddr[31:OffW+2];
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = {base_q, cnt_q, 2'b00};
        if (flush) begin
          valid_d = '0;
          abort_d = 1'b1;
        end
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            tag_we  = 1'b1;
            abort_d = 1'b0;
            state_d = StIdle;
            // A flush seen at any point of the fill, including now, leaves the line invalid.
            if (!abort_q && !flush) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[fill_idx][cnt_q] <= mem_rdata;
    if (tag_we)  tag_q[fill_idx]         <= base_q[BaseW-1:IdxW];
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: a line-residency model predicts every output each cycle,
// and directed fetch sequences pin miss penalties and refill address order.
module tb_icache_dm;

  localparam int unsigned L  = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned LB = 4 * W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int cmp_total = 0;
  int cmp_fail  = 0;
  bit chk_en    = 1'b0;
  int ack_period = 1;
  int req_cycles = 0;
  logic [31:0] ack_log [$];

  // Model: which line base each set holds, plus the refill in progress.
  logic [31:0] res_base [L];
  bit          res_ok   [L];
  bit          fill_act;
  logic [31:0] fill_base;
  int          fill_got;
  bit          fill_abort;

  icache_dm #(.LINES(L), .WORDS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .iaddr     (iaddr),
    .idata     (idata),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {16'hC0DE, a[15:0] & 16'hFFFC};
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LB) % L);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % LB);
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return res_ok[idx_of(a)] && (res_base[idx_of(a)] == line_of(a));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_act   <= 1'b0;
      fill_base  <= '0;
      fill_got   <= 0;
      fill_abort <= 1'b0;
      for (int i = 0; i < L; i++) res_ok[i] <= 1'b0;
    end else if (!fill_act) begin
      if (flush) begin
        for (int i = 0; i < L; i++) res_ok[i] <= 1'b0;
      end else if (!resident(iaddr)) begin
        fill_act   <= 1'b1;
        fill_base  <= line_of(iaddr);
        fill_got   <= 0;
        fill_abort <= 1'b0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < L; i++) res_ok[i] <= 1'b0;
        fill_abort <= 1'b1;
      end
      if (mem_ack) begin
        if (fill_got == W - 1) begin
          fill_act   <= 1'b0;
          fill_abort <= 1'b0;
          if (!fill_abort && !flush) begin
            res_ok[idx_of(fill_base)]   <= 1'b1;
            res_base[idx_of(fill_base)] <= fill_base;
          end
        end else begin
          fill_got <= fill_got + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_stall;
      logic [31:0] e_addr;
      e_stall = fill_act || !resident(iaddr);
      e_addr  = fill_act ? fill_base + 32'(4 * fill_got) : 32'h0;
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("idata", idata, e_stall ? 32'h0 : mem_fn(iaddr));
      chk("mem_req", {31'b0, mem_req}, {31'b0, fill_act});
      chk("mem_addr", mem_addr, e_addr);
    end
  end

  // One fetch cycle: drive inputs, answer the memory, sample, then cross the edge.
  task automatic cyc(input logic [31:0] a, input logic fl, output logic s, output logic [31:0] d);
    iaddr = a;
    flush = fl;
    #1;
    if (ack_period <= 1) begin
      mem_ack = 1'b1;
    end else if (mem_req) begin
      req_cycles++;
      mem_ack = (req_cycles >= ack_period);
      if (mem_ack) req_cycles = 0;
    end else begin
      mem_ack    = 1'b0;
      req_cycles = 0;
    end
    #1;
    s = stall;
    d = idata;
    if (mem_req && mem_ack) ack_log.push_back(mem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int stalls, output logic [31:0] d);
    logic s;
    stalls = 0;
    d      = '0;
    for (int i = 0; i < 100; i++) begin
      cyc(a, 1'b0, s, d);
      if (!s) return;
      stalls++;
    end
    cmp_total++;
    cmp_fail++;
    $display("FAIL fetch_bound: addr %h still stalled after %0d cycles, required a hit", a, stalls);
  endtask

  task automatic chk_line(input string name, input int start, input logic [31:0] base);
    for (int i = 0; i < W; i++)
      chk($sformatf("%s_w%0d", name, i), ack_log[start+i], base + 32'(4 * i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        s;
    logic [31:0] d;
    rst     = 1'b0;
    iaddr   = 32'h0;
    flush   = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_stall", {31'b0, stall}, 32'd1);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_idata", idata, 32'h0);
    rst = 1'b1;

    // Cold miss then hit
    ack_log.delete();
    fetch(32'h0000_0104, n, d);
    chk("cold_stalls", 32'(n), 32'd5);
    chk("cold_idata", d, 32'hC0DE_0104);
    chk("cold_nacks", 32'(ack_log.size()), 32'd4);
    chk_line("cold", 0, 32'h0000_0100);
    cyc(32'h0000_010C, 1'b0, s, d);
    chk("hit_stall", {31'b0, s}, 32'd0);
    chk("hit_idata", d, 32'hC0DE_010C);

    // Conflict eviction on set 0
    ack_log.delete();
    fetch(32'h0000_0200, n, d);
    chk("evict_stalls", 32'(n), 32'd5);
    chk_line("evict", 0, 32'h0000_0200);
    fetch(32'h0000_0100, n, d);
    chk("refetch_stalls", 32'(n), 32'd5);

    // Flush in idle: this cycle still hits, the next fetch misses
    cyc(32'h0000_0100, 1'b1, s, d);
    chk("flush_idle_stall", {31'b0, s}, 32'd0);
    chk("flush_idle_idata", d, 32'hC0DE_0100);
    fetch(32'h0000_0100, n, d);
    chk("after_flush_stalls", 32'(n), 32'd5);

    // Redirect after the second ack of a 0x100 refill
    fetch(32'h0000_0200, n, d);
    ack_log.delete();
    repeat (3) cyc(32'h0000_0100, 1'b0, s, d);
    fetch(32'h0000_0340, n, d);
    chk("redirect_stalls", 32'(n), 32'd7);
    chk("redirect_idata", d, 32'hC0DE_0340);
    chk("redirect_nacks", 32'(ack_log.size()), 32'd8);
    chk_line("redir_a", 0, 32'h0000_0100);
    chk_line("redir_b", 4, 32'h0000_0340);
    fetch(32'h0000_0100, n, d);
    chk("redirect_back_stalls", 32'(n), 32'd0);

    // Wait states: ack on every third request cycle
    ack_period = 3;
    ack_log.delete();
    fetch(32'h0000_0530, n, d);
    chk("wait_stalls", 32'(n), 32'd13);
    chk("wait_idata", d, 32'hC0DE_0530);
    chk_line("wait", 0, 32'h0000_0530);
    ack_period = 1;

    // Flush mid-fill: fill completes but stays invalid, so the fetch misses again
    cyc(32'h0000_0600, 1'b0, s, d);
    cyc(32'h0000_0600, 1'b0, s, d);
    cyc(32'h0000_0600, 1'b1, s, d);
    fetch(32'h0000_0600, n, d);
    chk("flush_fill_stalls", 32'(n), 32'd7);
    // Flush on the final ack
    repeat (4) cyc(32'h0000_0650, 1'b0, s, d);
    cyc(32'h0000_0650, 1'b1, s, d);
    fetch(32'h0000_0650, n, d);
    chk("flush_last_stalls", 32'(n), 32'd5);

    // Asynchronous reset between acks
    fetch(32'h0000_0344, n, d);
    fetch(32'h0000_0344, n, d);
    chk("pre_reset_hit", 32'(n), 32'd0);
    cyc(32'h0000_0700, 1'b0, s, d);
    cyc(32'h0000_0700, 1'b0, s, d);
    #2;
    rst = 1'b0;
    #1;
    chk("async_req", {31'b0, mem_req}, 32'd0);
    chk("async_stall", {31'b0, stall}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fetch(32'h0000_0344, n, d);
    chk("post_reset_stalls", 32'(n), 32'd5);
    chk("post_reset_idata", d, 32'hC0DE_0344);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

endmodule
